cdnsusbhs_load_sync_feed: RTL and testbench

//  Transmit-side feeder for the load synchronizer. Watches a txclk-domain source value
//  and issues single-cycle txload pulses with registered txdata when the value changes
//  or a resend is forced. Spaces pulses by at least GAP_CYCLES so each load completes the
//  req/ack round trip. Updates arriving inside the gap are coalesced: only the latest

---
 rtl/cdnsusbhs_load_sync_feed.sv | 108 ++++++++++
 tb/tb_cdnsusbhs_load_sync_feed.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cdnsusbhs_load_sync_feed.sv
// Transmit-side feeder for the load synchronizer: emits spaced, single-cycle txload pulses
// with registered txdata whenever the source value changes or a resend is forced.
module cdnsusbhs_load_sync_feed #(
  parameter int unsigned DATA_SYNC_WIDTH = 32'd1,
  parameter int unsigned GAP_CYCLES      = 32'd8
) (
  input  logic                       txclk_i,
  input  logic                       txrst_i,
  input  logic [DATA_SYNC_WIDTH-1:0] srcdata_i,
  input  logic                       srcforce_i,
  input  logic                       coalclr_i,
  output logic                       txload_o,
  output logic [DATA_SYNC_WIDTH-1:0] txdata_o,
  output logic                       busy_o,
  output logic [7:0]                 coalcnt_o
);

  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       pending_q, pending_d;
  logic                       txload_q, txload_d;
  logic [DATA_SYNC_WIDTH-1:0] txdata_q, txdata_d;
  logic [DATA_SYNC_WIDTH-1:0] srcdata_q;
  logic                       busy_q, busy_d;
  logic [7:0]                 coalcnt_q, coalcnt_d;

  logic evt;
  logic load;
  logic coal_inc;

  assign evt  = (srcdata_i != txdata_q) | srcforce_i;
  // A load fires from IDLE or at the end of a gap whenever there is demand.
  assign load = (pending_q | evt) & ((state_q == StIdle) | (cnt_q == 8'd0));

  always_ff @(posedge txclk_i) begin
    if (txrst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load) state_d = StGap;
      StGap:  if ((cnt_q == 8'd0) && !load) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    txload_d  = load;
    txdata_d  = txdata_q;
    busy_d    = (state_d == StGap);
    coalcnt_d = coalcnt_q;
    coal_inc  = 1'b0;

    if (load) begin
      cnt_d     = GapLoad;
      pending_d = 1'b0;
      txdata_d  = srcdata_i;
    end else if (state_q == StGap) begin
      cnt_d = cnt_q - 8'd1;
      if (evt) pending_d = 1'b1;
      // Only changes that overwrite an already-pending update count as coalesced.
      coal_inc = pending_q & (srcdata_i != srcdata_q);
    end

    if (coalclr_i) begin
      coalcnt_d = 8'd0;
    end else if (coal_inc && (coalcnt_q != 8'hFF)) begin
      coalcnt_d = coalcnt_q + 8'd1;
    end
  end

  always_ff @(posedge txclk_i) begin
    if (txrst_i) begin
      cnt_q     <= 8'd0;
      pending_q <= 1'b1;
      txload_q  <= 1'b0;
      txdata_q  <= '0;
      srcdata_q <= '0;
      busy_q    <= 1'b0;
      coalcnt_q <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      txload_q  <= txload_d;
      txdata_q  <= txdata_d;
      srcdata_q <= srcdata_i;
      busy_q    <= busy_d;
      coalcnt_q <= coalcnt_d;
    end
  end

  assign txload_o  = txload_q;
  assign txdata_o  = txdata_q;
  assign busy_o    = busy_q;
  assign coalcnt_o = coalcnt_q;

endmodule

// File: tb/tb_cdnsusbhs_load_sync_feed.sv
// Directed bench for cdnsusbhs_load_sync_feed with DATA_SYNC_WIDTH=8, GAP_CYCLES=4.
module tb_cdnsusbhs_load_sync_feed;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] srcdata;
  logic       srcforce;
  logic       coalclr;
  logic       txload;
  logic [7:0] txdata;
  logic       busy;
  logic [7:0] coalcnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  cdnsusbhs_load_sync_feed #(
    .DATA_SYNC_WIDTH(8),
    .GAP_CYCLES     (4)
  ) dut (
    .txclk_i   (clk),
    .txrst_i   (rst),
    .srcdata_i (srcdata),
    .srcforce_i(srcforce),
    .coalclr_i (coalclr),
    .txload_o  (txload),
    .txdata_o  (txdata),
    .busy_o    (busy),
    .coalcnt_o (coalcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; srcdata = 8'h5A; srcforce = 1'b0; coalclr = 1'b0;
    // 1: reset and initial load
    tick(); tick();
    chk("rst_txload", 32'(txload), 32'd0);
    chk("rst_txdata", 32'(txdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_coalcnt", 32'(coalcnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("init_txload", 32'(txload), 32'd1);
    chk("init_txdata", 32'(txdata), 32'h5A);
    chk("init_busy", 32'(busy), 32'd1);
    tick();
    chk("init_txload_drop", 32'(txload), 32'd0);
    chk("init_busy2", 32'(busy), 32'd1);
    tick();
    chk("init_busy3", 32'(busy), 32'd1);
    tick();
    chk("init_busy4", 32'(busy), 32'd1);
    tick();
    chk("init_idle_busy", 32'(busy), 32'd0);
    chk("init_idle_txload", 32'(txload), 32'd0);
    tick();
    chk("init_no_extra", 32'(txload), 32'd0);

    // 2: single change from IDLE, one-cycle latency
    srcdata = 8'h3C;
    tick();
    chk("chg_txload", 32'(txload), 32'd1);
    chk("chg_txdata", 32'(txdata), 32'h3C);
    chk("chg_coalcnt", 32'(coalcnt), 32'd0);

    // 3: three back-to-back changes coalesce into one load 4 cycles later
    srcdata = 8'h11; tick();
    chk("coal_txload_a", 32'(txload), 32'd0);
    srcdata = 8'h22; tick();
    chk("coal_cnt_a", 32'(coalcnt), 32'd1);
    srcdata = 8'h33; tick();
    chk("coal_txload_b", 32'(txload), 32'd0);
    chk("coal_cnt_b", 32'(coalcnt), 32'd2);
    tick();
    chk("coal_txload", 32'(txload), 32'd1);
    chk("coal_txdata", 32'(txdata), 32'h33);
    repeat (4) tick();
    chk("coal_idle", 32'(busy), 32'd0);

    // 4: forced resend in IDLE and in GAP
    srcforce = 1'b1; tick(); srcforce = 1'b0;
    chk("force_idle_txload", 32'(txload), 32'd1);
    chk("force_idle_txdata", 32'(txdata), 32'h33);
    tick();
    srcforce = 1'b1; tick(); srcforce = 1'b0;
    chk("force_gap_nopulse", 32'(txload), 32'd0);
    tick();
    chk("force_gap_wait", 32'(txload), 32'd0);
    tick();
    chk("force_gap_txload", 32'(txload), 32'd1);
    chk("force_gap_txdata", 32'(txdata), 32'h33);
    chk("force_gap_coal", 32'(coalcnt), 32'd2);
    repeat (4) tick();
    chk("force_idle_again", 32'(busy), 32'd0);

    // 5: saturate the coalesce counter, then clear against an increment
    for (int i = 0; i < 700; i++) begin
      srcdata = 8'(i + 8'h40);
      tick();
    end
    chk("sat_coalcnt", 32'(coalcnt), 32'hFF);
    repeat (12) tick();
    chk("sat_hold", 32'(coalcnt), 32'hFF);
    chk("sat_idle", 32'(busy), 32'd0);
    srcdata = 8'hA0; tick();
    chk("clr_load", 32'(txload), 32'd1);
    srcdata = 8'hA1; tick();
    chk("clr_first_chg", 32'(coalcnt), 32'hFF);
    srcdata = 8'hA2; coalclr = 1'b1; tick(); coalclr = 1'b0;
    chk("clr_wins", 32'(coalcnt), 32'd0);
    srcdata = 8'hA3; tick();
    chk("clr_recount", 32'(coalcnt), 32'd1);
    tick();
    chk("clr_reload", 32'(txload), 32'd1);
    chk("clr_reload_data", 32'(txdata), 32'hA3);
    repeat (6) tick();
    chk("pre_rst_idle", 32'(busy), 32'd0);

    // 6: reset mid-gap with a pending update
    srcdata = 8'hB0; tick();
    chk("mid_load", 32'(txload), 32'd1);
    srcdata = 8'hB1; tick();
    chk("mid_gap_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_txload", 32'(txload), 32'd0);
    chk("mid_rst_txdata", 32'(txdata), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_coal", 32'(coalcnt), 32'd0);
    tick();
    chk("post_rst_txload", 32'(txload), 32'd1);
    chk("post_rst_txdata", 32'(txdata), 32'hB1);
    tick();
    chk("post_rst_no_stale", 32'(txload), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
